uart_rx: RTL

Serial receiver that consumes the 8N1 line driven by the team's UART transmitter (115200 baud, LSB first, one stop bit) and delivers bytes on a valid/ready interface. It sits at the device pin side of the receive path: pin → `uart_rx` → byte consumer (FIFO or command parser). It uses 16× oversampling, majority-vote bit sampling, start-bit glitch rejection, framing-error and overrun reporting.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_os_tick.sv | 35 +++
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Constants and FSM state encoding shared by the UART TX/RX.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_OS     = 16;
    localparam int UART_DATA_W = 8;
    localparam int UART_CLK_HZ = 50_000_000;
    localparam int UART_BAUD   = 115200;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_os_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_os_tick
// Description : Oversample tick divider with synchronous restart.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_os_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic os_tick
);

    localparam int            c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // Suppressed during restart so the first tick lands a full DIV after the start edge
    assign os_tick = (r_cnt == c_last) && !restart;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, 16x oversampling with majority vote,
//               valid/ready byte output, framing-error and overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = UART_CLK_HZ,
    parameter int BAUD   = UART_BAUD,
    parameter int OS     = UART_OS,
    parameter int DIV    = CLK_HZ / (BAUD * OS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rxd,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   rx_busy
);

    logic                   r_sync1;
    logic                   r_rxs;
    uart_state_t            r_state;
    uart_state_t            w_state_nxt;
    logic [3:0]             r_os_cnt;
    logic [2:0]             r_bit_idx;
    logic                   r_smp7;
    logic                   r_smp8;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic w_os_tick;
    logic w_restart;
    logic w_maj;
    logic w_decide;
    logic w_bit_end;
    logic w_shift_en;
    logic w_deliver;
    logic w_ferr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxs   <= r_sync1;
        end
    end

    uart_os_tick #(
        .DIV     (DIV)
    ) u_os_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .os_tick (w_os_tick)
    );

    // Third vote is the live sample on the decision tick
    assign w_maj     = (r_smp7 & r_smp8) | (r_smp7 & r_rxs) | (r_smp8 & r_rxs);
    assign w_decide  = w_os_tick && (r_os_cnt == 4'd9);
    assign w_bit_end = w_os_tick && (r_os_cnt == 4'd15);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_shift_en  = 1'b0;
        w_deliver   = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_rxs) begin
                    w_state_nxt = ST_START;
                    w_restart   = 1'b1;
                end
            end
            ST_START: begin
                if (w_decide && w_maj) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_shift_en = w_decide;
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave at mid-stop so a start edge right after the stop bit is seen
                if (w_decide) begin
                    if (w_maj) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (r_rxs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_os_cnt  <= 4'd0;
            r_bit_idx <= 3'd0;
            r_smp7    <= 1'b1;
            r_smp8    <= 1'b1;
            r_shift   <= '0;
        end else begin
            if (w_restart || (r_state == ST_IDLE)) begin
                r_os_cnt  <= 4'd0;
                r_bit_idx <= 3'd0;
            end else if (w_os_tick) begin
                r_os_cnt <= r_os_cnt + 4'd1;
                if ((r_state == ST_DATA) && (r_os_cnt == 4'd15)) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end
            if (w_os_tick && (r_os_cnt == 4'd7)) begin
                r_smp7 <= r_rxs;
            end
            if (w_os_tick && (r_os_cnt == 4'd8)) begin
                r_smp8 <= r_rxs;
            end
            if (w_shift_en) begin
                r_shift <= {w_maj, r_shift[UART_DATA_W-1:1]};
            end
        end
    end

    // Holding register: accept and deliver in one cycle is a reload, not an overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;
            if (w_deliver) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign rx_busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire
